// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: PC, instruction-memory and decode-side signals of the VR16 fetch stage.
// master = fetch stage, slave = its surroundings (PC, memory, decode).
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] pc_addr;
    logic                  flush;
    logic                  pc_advance;
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_ready;

    modport master (
        input  pc_addr, flush, imem_rvalid, imem_rdata, instr_ready,
        output pc_advance, imem_req, imem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output pc_addr, flush, imem_rvalid, imem_rdata, instr_ready,
        input  pc_advance, imem_req, imem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: VR16 fetch stage, one outstanding imem read feeding an in-order instruction buffer.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
//
// state   | meaning
// IDLE    | no read outstanding
// WAIT    | one read outstanding, its response will be buffered
// DISCARD | one stale read outstanding, its response will be dropped
module instruction_fetch #(
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] data_buf [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_buf   [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] req_pc;

    logic                  waiting;
    logic                  rsp;
    logic                  buf_valid;
    logic                  bypass;
    logic                  head_valid;
    logic                  pop;
    logic                  buf_pop;
    logic                  push;
    logic                  issue;
    logic [OCC_W-1:0]      occupancy;

    always_comb begin
        waiting   = (state == WAIT);
        rsp       = waiting & bus.imem_rvalid;
        buf_valid = (count != '0);
`ifdef FETCH_BYPASS_EN
        bypass    = rsp & ~bus.flush & ~buf_valid;
`else
        bypass    = 1'b0;
`endif
        head_valid = buf_valid | bypass;
        pop        = head_valid & bus.instr_ready;
        buf_pop    = pop & buf_valid;
        // a response consumed by decode in the bypass cycle never occupies a slot
        push       = rsp & ~bus.flush & ~(bypass & bus.instr_ready);
        // the in-flight read already owns a slot, so a new read needs room beyond it
        occupancy  = OCC_W'(count) + OCC_W'(waiting) - OCC_W'(pop);
        issue      = ~reset & ~bus.flush & (occupancy < OCC_W'(FIFO_DEPTH))
                     & ((state == IDLE) | rsp);
    end

    assign bus.imem_req    = issue;
    assign bus.pc_advance  = issue;
    assign bus.imem_addr   = bus.pc_addr;
    assign bus.instr_valid = head_valid;
`ifdef FETCH_BYPASS_EN
    assign bus.instr       = bypass ? bus.imem_rdata : data_buf[rd_ptr];
    assign bus.instr_pc    = bypass ? req_pc : pc_buf[rd_ptr];
`else
    assign bus.instr       = data_buf[rd_ptr];
    assign bus.instr_pc    = pc_buf[rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            req_pc <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_buf[i] <= '0;
                pc_buf[i]   <= '0;
            end
        end else if (bus.flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            // a response arriving with the flush retires the outstanding read
            case (state)
                WAIT:    state <= bus.imem_rvalid ? IDLE : DISCARD;
                DISCARD: state <= bus.imem_rvalid ? IDLE : DISCARD;
                default: state <= IDLE;
            endcase
        end else begin
            if (push) begin
                data_buf[wr_ptr] <= bus.imem_rdata;
                pc_buf[wr_ptr]   <= req_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (buf_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(buf_pop);
            if (issue) begin
                req_pc <= bus.pc_addr;
            end
            case (state)
                IDLE:    state <= issue ? WAIT : IDLE;
                WAIT:    if (bus.imem_rvalid) state <= issue ? WAIT : IDLE;
                DISCARD: if (bus.imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench; the bench plays program_counter, instruction memory and decode.
// Every issued fetch queues {pc, mem[pc]}; a monitor checks the decode head against the queue front.
module tb_instruction_fetch;
    localparam int DEPTH = 2;
    localparam int AW    = 16;
    localparam int DW    = 16;
`ifdef FETCH_BYPASS_EN
    localparam int HEAD_LAG = 1;
    localparam bit BYP      = 1'b1;
`else
    localparam int HEAD_LAG = 2;
    localparam bit BYP      = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    instruction_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    instruction_fetch #(
        .FIFO_DEPTH(DEPTH),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   pops        = 0;

    // PC / memory model state
    logic [15:0] pc;
    logic [15:0] flush_target;
    bit          mem_busy;
    int          mem_left;
    int          mem_lat;
    bit          rnd_lat;
    logic [15:0] mem_addr;

    logic        s_req, s_adv, s_valid, s_rvalid;
    logic [15:0] s_addr, s_instr, s_ipc;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    // monitor: head must equal the oldest outstanding fetch
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.instr_valid === 1'b1) begin
                check("valid_has_entry", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("instr_pc", 32'(bus.instr_pc), 32'(exp_q[0].pc));
                    check("instr", 32'(bus.instr), 32'(exp_q[0].data));
                    if (bus.instr_ready) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
            if (bus.flush) exp_q.delete();
        end
    end

    task automatic step();
        exp_t e;
        @(negedge clk);
        #1;
        s_req    = bus.imem_req;
        s_adv    = bus.pc_advance;
        s_addr   = bus.imem_addr;
        s_valid  = bus.instr_valid;
        s_instr  = bus.instr;
        s_ipc    = bus.instr_pc;
        s_rvalid = bus.imem_rvalid;
        if (reset) begin
            check("req_in_reset", 32'(s_req), 0);
            check("adv_in_reset", 32'(s_adv), 0);
            pc = 16'h0000;
        end else begin
            check("adv_eq_req", 32'(s_adv), 32'(s_req));
            if (s_req) begin
                check("req_no_flush", 32'(bus.flush), 0);
                check("imem_addr", 32'(s_addr), 32'(pc));
                check("one_outstanding", 32'(mem_busy), 0);
                check("occupancy", 32'(exp_q.size() < DEPTH), 1);
                if (!bus.flush) begin
                    e.pc   = pc;
                    e.data = pc ^ 16'hA5A5;
                    exp_q.push_back(e);
                end
                mem_busy = 1'b1;
                mem_addr = s_addr;
                mem_left = rnd_lat ? int'($urandom_range(1, 3)) : mem_lat;
            end
            if (bus.flush) pc = flush_target;
            else if (s_adv) pc = pc + 16'd1;
        end
        @(posedge clk);
        #1;
        bus.pc_addr     = pc;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 16'($urandom);
        if (mem_busy) begin
            mem_left--;
            if (mem_left == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_addr ^ 16'hA5A5;
                mem_busy        = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.flush = 1'b0;
        step();
        for (int g = 0; g < 8 && mem_busy; g++) step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        int pops_start;
        bit seen;
        reset           = 1'b1;
        pc              = 16'h0000;
        flush_target    = 16'h0000;
        mem_busy        = 1'b0;
        mem_left        = 0;
        mem_lat         = 1;
        rnd_lat         = 1'b0;
        mem_addr        = 16'h0000;
        bus.pc_addr     = 16'h0000;
        bus.flush       = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 16'h0000;
        bus.instr_ready = 1'b1;

        // A: streaming with 1-cycle memory, decode always ready
        mem_lat = 1;
        do_reset();
        check("rst_valid", 32'(s_valid), 0);
        check("rst_instr", 32'(s_instr), 0);
        check("rst_instr_pc", 32'(s_ipc), 0);
        for (int i = 0; i < 12; i++) begin
            step();
            check("a_req_every_cycle", 32'(s_req), 1);
            if (i == 1) begin
                check("a_rvalid", 32'(s_rvalid), 1);
                check("a_first_valid", 32'(s_valid), 32'(BYP));
            end
            if (i >= HEAD_LAG) check("a_head_pc", 32'(s_ipc), 32'(16'(i - HEAD_LAG)));
        end

        // B: decode stalled from the start
        bus.instr_ready = 1'b0;
        do_reset();
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            nreq += int'(s_req);
        end
        check("b_req_count", 32'(nreq), 2);
        check("b_req_low", 32'(s_req), 0);
        check("b_adv_low", 32'(s_adv), 0);
        check("b_valid", 32'(s_valid), 1);
        check("b_head_pc", 32'(s_ipc), 0);
        check("b_head_instr", 32'(s_instr), 32'hA5A5);
        bus.instr_ready = 1'b1;
        step();
        check("b_resume_req", 32'(s_req), 1);
        check("b_resume_addr", 32'(s_addr), 2);
        run(6);

        // C: flush while a 3-cycle read is outstanding
        mem_lat = 3;
        do_reset();
        step();
        check("c_req0", 32'(s_req), 1);
        bus.flush    = 1'b1;
        flush_target = 16'h3333;
        step();
        bus.flush = 1'b0;
        step();
        check("c_valid_after_flush", 32'(s_valid), 0);
        check("c_no_req_discard", 32'(s_req), 0);
        step();
        check("c_stale_rvalid", 32'(s_rvalid), 1);
        check("c_no_req_stale", 32'(s_req), 0);
        step();
        check("c_req_target", 32'(s_req), 1);
        check("c_addr_target", 32'(s_addr), 32'h3333);
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            step();
            if (s_valid) begin
                seen = 1'b1;
                check("c_first_instr_pc", 32'(s_ipc), 32'h3333);
            end
        end
        check("c_valid_seen", 32'(seen), 1);

        // D: flush coincident with a response while decode is stalled
        mem_lat         = 1;
        bus.instr_ready = 1'b0;
        do_reset();
        run(2);
        bus.flush    = 1'b1;
        flush_target = 16'h5A00;
        step();
        check("d_rvalid_on_flush", 32'(s_rvalid), 1);
        bus.flush = 1'b0;
        step();
        check("d_valid_cleared", 32'(s_valid), 0);
        check("d_req_target", 32'(s_req), 1);
        check("d_addr_target", 32'(s_addr), 32'h5A00);
        bus.instr_ready = 1'b1;
        run(8);

        // E: reset while a read is outstanding, response lands just after reset
        mem_lat = 2;
        do_reset();
        run(2);
        step();
        check("e_req_pc1", 32'(s_req), 1);
        check("e_addr_pc1", 32'(s_addr), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("e_stale_rvalid", 32'(s_rvalid), 1);
        check("e_valid", 32'(s_valid), 0);
        check("e_instr", 32'(s_instr), 0);
        check("e_instr_pc", 32'(s_ipc), 0);
        check("e_restart_req", 32'(s_req), 1);
        check("e_restart_addr", 32'(s_addr), 0);
        run(8);

        // F: random stalls, latencies and redirects (including 0xFFFF)
        rnd_lat = 1'b1;
        do_reset();
        pops_start = pops;
        for (int i = 0; i < 2000; i++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.flush       = ($urandom_range(0, 19) == 0);
            flush_target    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            step();
        end
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b1;
        run(20);
        check("f_progress", 32'((pops - pops_start) > 200), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
